// File: rtl/decode_pkg.sv
// Shared encodings for the decode stage: opcodes, ALU operations, result sources,
// immediate formats and the canonical NOP.
package decode_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [3:0] {
    ALU_ADD    = 4'b0000,
    ALU_SUB    = 4'b0001,
    ALU_AND    = 4'b0010,
    ALU_OR     = 4'b0011,
    ALU_XOR    = 4'b0100,
    ALU_SLT    = 4'b0101,
    ALU_SLL    = 4'b0110,
    ALU_SRL    = 4'b0111,
    ALU_SRA    = 4'b1000,
    ALU_SLTU   = 4'b1001,
    ALU_PASS_B = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } res_sel_e;

  typedef enum logic [2:0] {
    FMT_NONE,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_e;

endpackage

// File: rtl/decode_stage_pl_regfile.sv
// Integer register file with x0 hardwired to zero and same-cycle writeback bypass
// on both read ports.
module regfile_bypass #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_COUNT  = 32,
  localparam int RA_W      = $clog2(REG_COUNT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [RA_W-1:0]       wa,
  input  logic [DATA_WIDTH-1:0] wd,
  input  logic [RA_W-1:0]       ra1,
  input  logic [RA_W-1:0]       ra2,
  output logic [DATA_WIDTH-1:0] rd1,
  output logic [DATA_WIDTH-1:0] rd2
);

  logic [DATA_WIDTH-1:0] regs [REG_COUNT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
    end else if (we && wa != '0) begin
      regs[wa] <= wd;
    end
  end

  // Writeback data wins over the array so decode sees the value being retired this cycle.
  assign rd1 = (ra1 == '0) ? '0 : (we && wa == ra1) ? wd : regs[ra1];
  assign rd2 = (ra2 == '0) ? '0 : (we && wa == ra2) ? wd : regs[ra2];

endmodule

// File: rtl/decode_stage_pl.sv
// Decode stage: IF/ID register with flush/stall, register read with bypass,
// control and immediate decode, and load-use hazard detection.
module decode_stage_pl
  import decode_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int REG_COUNT     = 32,
  localparam int RA_W         = $clog2(REG_COUNT)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [ADDRESS_WIDTH-1:0] pc_f,
  input  logic [ADDRESS_WIDTH-1:0] pc_plus4_f,
  input  logic [31:0]              instr_f,
  input  logic                     stall_d,
  input  logic                     flush_d,
  input  logic                     reg_write_w,
  input  logic [RA_W-1:0]          rd_w,
  input  logic [DATA_WIDTH-1:0]    result_w,
  input  logic [RA_W-1:0]          rd_e,
  input  logic [1:0]               res_src_e,
  output logic                     stall_f,
  output logic                     flush_e,
  output logic                     valid_d,
  output logic                     illegal_d,
  output logic                     reg_write_d,
  output logic                     mem_write_d,
  output logic                     jump_d,
  output logic                     branch_d,
  output logic [1:0]               res_src_d,
  output logic [3:0]               alu_control_d,
  output logic [2:0]               funct3_d,
  output logic                     alu_src_a_d,
  output logic                     alu_src_b_d,
  output logic                     adder_src_d,
  output logic [DATA_WIDTH-1:0]    rd1_d,
  output logic [DATA_WIDTH-1:0]    rd2_d,
  output logic [RA_W-1:0]          rs1_d,
  output logic [RA_W-1:0]          rs2_d,
  output logic [RA_W-1:0]          rd_d,
  output logic [DATA_WIDTH-1:0]    imm_val_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d
);

  logic [31:0]              instr_p0;
  logic [ADDRESS_WIDTH-1:0] pc_p0;
  logic [ADDRESS_WIDTH-1:0] pc_plus4_p0;
  logic                     vld_p0;

  logic [6:0]         opcode;
  logic               funct7_b5;
  logic               rs1_used;
  logic               rs2_used;
  logic               hazard;
  imm_fmt_e           imm_fmt;
  logic signed [31:0] imm32;

  function automatic alu_op_e alu_decode(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'b000:  return (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic logic signed [31:0] imm_gen(input logic [31:0] ins, input imm_fmt_e fmt);
    case (fmt)
      FMT_I:   return {{20{ins[31]}}, ins[31:20]};
      FMT_S:   return {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   return {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   return {ins[31:12], 12'b0};
      FMT_J:   return {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
      default: return '0;
    endcase
  endfunction

  // ---- IF/ID register: flush beats stall, stall beats capture ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p0    <= NOP_INSTR;
      pc_p0       <= '0;
      pc_plus4_p0 <= '0;
      vld_p0      <= 1'b0;
    end else if (flush_d) begin
      instr_p0 <= NOP_INSTR;
      vld_p0   <= 1'b0;
    end else if (!(stall_d || stall_f)) begin
      instr_p0    <= instr_f;
      pc_p0       <= pc_f;
      pc_plus4_p0 <= pc_plus4_f;
      vld_p0      <= 1'b1;
    end
  end

  assign opcode     = instr_p0[6:0];
  assign funct7_b5  = instr_p0[30];
  assign funct3_d   = instr_p0[14:12];
  assign rs1_d      = instr_p0[15 +: RA_W];
  assign rs2_d      = instr_p0[20 +: RA_W];
  assign rd_d       = instr_p0[7 +: RA_W];
  assign valid_d    = vld_p0;
  assign pc_d       = pc_p0;
  assign pc_plus4_d = pc_plus4_p0;

  // ---- ID combinational decode; an empty slot decodes to all-zero controls ----
  always_comb begin
    reg_write_d   = 1'b0;
    mem_write_d   = 1'b0;
    jump_d        = 1'b0;
    branch_d      = 1'b0;
    illegal_d     = 1'b0;
    res_src_d     = RES_ALU;
    alu_control_d = ALU_ADD;
    alu_src_a_d   = 1'b0;
    alu_src_b_d   = 1'b0;
    adder_src_d   = 1'b0;
    imm_fmt       = FMT_NONE;
    if (vld_p0) begin
      case (opcode)
        OP_R: begin
          reg_write_d   = 1'b1;
          alu_control_d = alu_decode(funct3_d, funct7_b5, 1'b1);
        end
        OP_I: begin
          reg_write_d   = 1'b1;
          alu_src_b_d   = 1'b1;
          alu_control_d = alu_decode(funct3_d, funct7_b5, 1'b0);
          imm_fmt       = FMT_I;
        end
        OP_LOAD: begin
          reg_write_d = 1'b1;
          res_src_d   = RES_MEM;
          alu_src_b_d = 1'b1;
          imm_fmt     = FMT_I;
        end
        OP_STORE: begin
          mem_write_d = 1'b1;
          alu_src_b_d = 1'b1;
          imm_fmt     = FMT_S;
        end
        OP_BRANCH: begin
          branch_d      = 1'b1;
          alu_control_d = ALU_SUB;
          imm_fmt       = FMT_B;
        end
        OP_JAL: begin
          reg_write_d = 1'b1;
          jump_d      = 1'b1;
          res_src_d   = RES_PC4;
          imm_fmt     = FMT_J;
        end
        OP_JALR: begin
          reg_write_d = 1'b1;
          jump_d      = 1'b1;
          res_src_d   = RES_PC4;
          adder_src_d = 1'b1;
          imm_fmt     = FMT_I;
        end
        OP_LUI: begin
          reg_write_d   = 1'b1;
          alu_src_b_d   = 1'b1;
          alu_control_d = ALU_PASS_B;
          imm_fmt       = FMT_U;
        end
        OP_AUIPC: begin
          reg_write_d = 1'b1;
          alu_src_a_d = 1'b1;
          alu_src_b_d = 1'b1;
          imm_fmt     = FMT_U;
        end
        default: illegal_d = 1'b1;
      endcase
    end
  end

  assign imm32     = imm_gen(instr_p0, imm_fmt);
  assign imm_val_d = DATA_WIDTH'(imm32);

  // Only the operands an instruction actually reads can trigger a load-use stall.
  assign rs1_used = !(opcode inside {OP_LUI, OP_AUIPC, OP_JAL});
  assign rs2_used = opcode inside {OP_R, OP_STORE, OP_BRANCH};
  assign hazard   = (res_src_e == RES_MEM) && (rd_e != '0) &&
                    ((rs1_used && rd_e == rs1_d) || (rs2_used && rd_e == rs2_d));
  assign stall_f  = hazard && vld_p0;
  assign flush_e  = stall_f;

  regfile_bypass #(
    .DATA_WIDTH(DATA_WIDTH),
    .REG_COUNT (REG_COUNT)
  ) u_regfile (
    .clk  (clk),
    .rst_n(rst_n),
    .we   (reg_write_w),
    .wa   (rd_w),
    .wd   (result_w),
    .ra1  (rs1_d),
    .ra2  (rs2_d),
    .rd1  (rd1_d),
    .rd2  (rd2_d)
  );

endmodule

// File: tb/tb_decode_stage_pl.sv
// Bench for decode_stage_pl: directed scenarios plus a randomized run against an
// instruction-level reference model of the IF/ID slot, register file and decoder.
module tb_decode_stage_pl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc_f, pc_plus4_f, instr_f;
  logic        stall_d, flush_d, reg_write_w;
  logic [4:0]  rd_w, rd_e;
  logic [31:0] result_w;
  logic [1:0]  res_src_e;
  logic        stall_f, flush_e, valid_d, illegal_d;
  logic        reg_write_d, mem_write_d, jump_d, branch_d;
  logic [1:0]  res_src_d;
  logic [3:0]  alu_control_d;
  logic [2:0]  funct3_d;
  logic        alu_src_a_d, alu_src_b_d, adder_src_d;
  logic [31:0] rd1_d, rd2_d, imm_val_d, pc_d, pc_plus4_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;

  int errors = 0;
  int checks = 0;

  logic [3:0]  alu_tab [8] = '{4'd0, 4'd6, 4'd5, 4'd9, 4'd4, 4'd7, 4'd3, 4'd2};
  logic [31:0] m_rf [32];
  logic [31:0] m_instr, m_pc, m_pc4;
  logic        m_vld;

  decode_stage_pl dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pc_plus4_f(pc_plus4_f), .instr_f(instr_f),
    .stall_d(stall_d), .flush_d(flush_d), .reg_write_w(reg_write_w), .rd_w(rd_w),
    .result_w(result_w), .rd_e(rd_e), .res_src_e(res_src_e), .stall_f(stall_f),
    .flush_e(flush_e), .valid_d(valid_d), .illegal_d(illegal_d), .reg_write_d(reg_write_d),
    .mem_write_d(mem_write_d), .jump_d(jump_d), .branch_d(branch_d), .res_src_d(res_src_d),
    .alu_control_d(alu_control_d), .funct3_d(funct3_d), .alu_src_a_d(alu_src_a_d),
    .alu_src_b_d(alu_src_b_d), .adder_src_d(adder_src_d), .rd1_d(rd1_d), .rd2_d(rd2_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d), .imm_val_d(imm_val_d), .pc_d(pc_d),
    .pc_plus4_d(pc_plus4_d)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time exceeded, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_f = 0; pc_plus4_f = 0; instr_f = 32'h00000013;
    stall_d = 0; flush_d = 0; reg_write_w = 0; rd_w = 0; result_w = 0;
    rd_e = 0; res_src_e = 0;
  endtask

  function automatic logic [31:0] ref_imm(input logic [31:0] ins);
    logic [31:0] s;
    s = 32'($signed(ins) >>> 31);
    case (ins[6:0])
      7'h13, 7'h03, 7'h67: return 32'($signed(ins) >>> 20);
      7'h23: return (s << 12) | (32'(ins[31:25]) << 5) | 32'(ins[11:7]);
      7'h63: return (s << 12) | (32'(ins[7]) << 11) | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      7'h37, 7'h17: return ins & 32'hFFFF_F000;
      7'h6F: return (s << 20) | (32'(ins[19:12]) << 12) | (32'(ins[20]) << 11) | (32'(ins[30:21]) << 1);
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [3:0] ref_alu(input logic [31:0] ins);
    logic [2:0] f3;
    f3 = ins[14:12];
    case (ins[6:0])
      7'h33: return (f3 == 0 && ins[30]) ? 4'd1 : (f3 == 5 && ins[30]) ? 4'd8 : alu_tab[f3];
      7'h13: return (f3 == 5 && ins[30]) ? 4'd8 : alu_tab[f3];
      7'h63: return 4'd1;
      7'h37: return 4'd10;
      default: return 4'd0;
    endcase
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    int k;
    r = $urandom;
    k = $urandom_range(0, 9);
    case (k)
      0: begin
        r[6:0] = 7'h33;
        r[31:25] = ((r[14:12] == 0 || r[14:12] == 5) && r[30]) ? 7'h20 : 7'h00;
      end
      1: begin
        r[6:0] = 7'h13;
        if (r[14:12] == 1) r[31:25] = 7'h00;
        if (r[14:12] == 5) r[31:25] = {1'b0, r[30], 5'b0};
      end
      2: r[6:0] = 7'h03;
      3: r[6:0] = 7'h23;
      4: r[6:0] = 7'h63;
      5: r[6:0] = 7'h6F;
      6: begin r[6:0] = 7'h67; r[14:12] = 3'b000; end
      7: r[6:0] = 7'h37;
      8: r[6:0] = 7'h17;
      default: r[6:0] = 7'h7F;
    endcase
    return r;
  endfunction

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    #12;
    checks++;
    if ({valid_d, illegal_d, reg_write_d, mem_write_d, jump_d, branch_d, stall_f, flush_e,
         alu_src_a_d, alu_src_b_d, adder_src_d} !== 11'b0) begin
      errors++; $display("FAIL reset_ctl: got %b expected 0", {valid_d, illegal_d, reg_write_d,
        mem_write_d, jump_d, branch_d, stall_f, flush_e, alu_src_a_d, alu_src_b_d, adder_src_d});
    end
    checks++;
    if ({res_src_d, alu_control_d, funct3_d, rd_d, rs1_d, rs2_d} !== 24'b0) begin
      errors++; $display("FAIL reset_fields: got %h expected 0", {res_src_d, alu_control_d, funct3_d, rd_d, rs1_d, rs2_d});
    end
    checks++;
    if ({rd1_d, rd2_d, imm_val_d, pc_d, pc_plus4_d} !== 160'b0) begin
      errors++; $display("FAIL reset_data: rd1=%h rd2=%h imm=%h pc=%h pc4=%h expected 0", rd1_d, rd2_d, imm_val_d, pc_d, pc_plus4_d);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_regfile_bypass();
    instr_f = 32'h00010093;
    tick();
    reg_write_w = 1; rd_w = 2; result_w = 32'h12345678;
    #1;
    checks++;
    if (rd1_d !== 32'h12345678) begin errors++; $display("FAIL bypass_rd1: got %h expected 12345678", rd1_d); end
    tick();
    reg_write_w = 0;
    #1;
    checks++;
    if (rd1_d !== 32'h12345678) begin errors++; $display("FAIL stored_rd1: got %h expected 12345678", rd1_d); end
    reg_write_w = 1; rd_w = 0; result_w = 32'hFFFFFFFF;
    #1;
    checks++;
    if (rd2_d !== 32'h0) begin errors++; $display("FAIL x0_bypass: got %h expected 0", rd2_d); end
    tick();
    reg_write_w = 0;
    #1;
    checks++;
    if (rd2_d !== 32'h0) begin errors++; $display("FAIL x0_write: got %h expected 0", rd2_d); end
  endtask

  task automatic test_addi();
    instr_f = 32'h00218213; pc_f = 32'h100; pc_plus4_f = 32'h104;
    tick();
    #1;
    checks++;
    if ({valid_d, reg_write_d, alu_src_b_d, mem_write_d, illegal_d} !== 5'b11100) begin
      errors++; $display("FAIL addi_ctl: got %b expected 11100", {valid_d, reg_write_d, alu_src_b_d, mem_write_d, illegal_d});
    end
    checks++;
    if ({alu_control_d, imm_val_d, rd_d, pc_d} !== {4'd0, 32'd2, 5'd4, 32'h100}) begin
      errors++; $display("FAIL addi_fields: alu=%h imm=%h rd=%0d pc=%h expected 0/2/4/100", alu_control_d, imm_val_d, rd_d, pc_d);
    end
  endtask

  task automatic test_branch_jal();
    instr_f = 32'h00534063;
    tick();
    #1;
    checks++;
    if ({branch_d, reg_write_d, alu_control_d, funct3_d, rs1_d, rs2_d} !== {1'b1, 1'b0, 4'd1, 3'b100, 5'd6, 5'd5}) begin
      errors++; $display("FAIL blt: br=%b rw=%b alu=%h f3=%b rs1=%0d rs2=%0d expected 1/0/1/100/6/5",
        branch_d, reg_write_d, alu_control_d, funct3_d, rs1_d, rs2_d);
    end
    instr_f = 32'h0080006F; pc_f = 32'h40; pc_plus4_f = 32'h44;
    tick();
    #1;
    checks++;
    if ({jump_d, reg_write_d, res_src_d, imm_val_d, pc_d, adder_src_d} !== {1'b1, 1'b1, 2'b10, 32'd8, 32'h40, 1'b0}) begin
      errors++; $display("FAIL jal: jmp=%b rw=%b res=%b imm=%h pc=%h adder=%b expected 1/1/10/8/40/0",
        jump_d, reg_write_d, res_src_d, imm_val_d, pc_d, adder_src_d);
    end
  endtask

  task automatic test_load_use();
    instr_f = 32'h001202B3;
    tick();
    rd_e = 4; res_src_e = 2'b01; instr_f = 32'h00A00093;
    #1;
    checks++;
    if ({stall_f, flush_e} !== 2'b11) begin errors++; $display("FAIL lu_rs1: got %b expected 11", {stall_f, flush_e}); end
    for (int c = 0; c < 2; c++) begin
      tick();
      #1;
      checks++;
      if ({rd_d, stall_f} !== {5'd5, 1'b1}) begin
        errors++; $display("FAIL lu_hold%0d: rd=%0d stall=%b expected 5/1", c, rd_d, stall_f);
      end
    end
    rd_e = 1;
    #1;
    checks++;
    if (stall_f !== 1'b1) begin errors++; $display("FAIL lu_rs2: got %b expected 1", stall_f); end
    rd_e = 0;
    #1;
    checks++;
    if ({stall_f, flush_e} !== 2'b00) begin errors++; $display("FAIL lu_x0: got %b expected 00", {stall_f, flush_e}); end
    tick();
    #1;
    checks++;
    if (rd_d !== 5'd1) begin errors++; $display("FAIL lu_release: rd=%0d expected 1", rd_d); end
    res_src_e = 0;
  endtask

  task automatic test_flush_stall();
    flush_d = 1; stall_d = 1;
    tick();
    #1;
    checks++;
    if ({valid_d, reg_write_d, mem_write_d, jump_d, branch_d, illegal_d, alu_src_b_d, res_src_d} !== 8'b0) begin
      errors++; $display("FAIL flush_over_stall: got %b expected 0",
        {valid_d, reg_write_d, mem_write_d, jump_d, branch_d, illegal_d, alu_src_b_d, res_src_d});
    end
    flush_d = 0; stall_d = 0;
  endtask

  task automatic test_async_reset();
    instr_f = 32'h00038093; reg_write_w = 1; rd_w = 7; result_w = 32'hDEADBEEF;
    tick();
    reg_write_w = 0;
    #1;
    checks++;
    if (rd1_d !== 32'hDEADBEEF) begin errors++; $display("FAIL pre_reset_rd1: got %h expected deadbeef", rd1_d); end
    #2 rst_n = 0;
    #1;
    checks++;
    if ({valid_d, reg_write_d, alu_src_b_d, rd1_d, pc_d} !== 35'b0) begin
      errors++; $display("FAIL async_reset: valid=%b rw=%b rd1=%h pc=%h expected 0", valid_d, reg_write_d, rd1_d, pc_d);
    end
    #2 rst_n = 1;
    tick();
    #1;
    checks++;
    if ({valid_d, rd1_d} !== {1'b1, 32'h0}) begin
      errors++; $display("FAIL reset_cleared_rf: valid=%b rd1=%h expected 1/0", valid_d, rd1_d);
    end
  endtask

  task automatic test_random();
    logic [31:0] n_instr, n_pc, n_pc4, e_imm, e_rd1, e_rd2;
    logic [6:0]  op;
    logic [4:0]  rs1, rs2;
    logic        n_vld, legal, e_stall, rs1u, rs2u, do_write;
    logic [7:0]  e_ctl;
    logic [1:0]  e_res;
    #1 rst_n = 0;
    #1 rst_n = 1;
    for (int i = 0; i < 32; i++) m_rf[i] = 0;
    m_instr = 32'h00000013; m_pc = 0; m_pc4 = 0; m_vld = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      instr_f = rand_instr();
      pc_f = $urandom; pc_plus4_f = pc_f + 4;
      flush_d = ($urandom_range(0, 7) == 0);
      stall_d = ($urandom_range(0, 7) == 0);
      reg_write_w = $urandom_range(0, 1);
      rd_w = ($urandom_range(0, 1) == 1) ? m_instr[19:15] : 5'($urandom);
      result_w = $urandom;
      rd_e = ($urandom_range(0, 1) == 1) ? m_instr[24:20] : 5'($urandom);
      res_src_e = 2'($urandom_range(0, 2));
      #1;
      op = m_instr[6:0]; rs1 = m_instr[19:15]; rs2 = m_instr[24:20];
      legal = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17};
      rs1u = !(op inside {7'h37, 7'h17, 7'h6F});
      rs2u = op inside {7'h33, 7'h23, 7'h63};
      e_stall = m_vld && res_src_e == 2'b01 && rd_e != 0 && ((rs1u && rd_e == rs1) || (rs2u && rd_e == rs2));
      e_ctl = {m_vld, m_vld && !legal,
               m_vld && (op inside {7'h33, 7'h13, 7'h03, 7'h6F, 7'h67, 7'h37, 7'h17}),
               m_vld && op == 7'h23, m_vld && (op == 7'h6F || op == 7'h67), m_vld && op == 7'h63,
               e_stall, e_stall};
      e_rd1 = (rs1 == 0) ? 0 : (reg_write_w && rd_w == rs1) ? result_w : m_rf[rs1];
      e_rd2 = (rs2 == 0) ? 0 : (reg_write_w && rd_w == rs2) ? result_w : m_rf[rs2];
      checks++;
      if ({valid_d, illegal_d, reg_write_d, mem_write_d, jump_d, branch_d, stall_f, flush_e} !== e_ctl) begin
        errors++; $display("FAIL rand_ctl cyc%0d instr=%h: got %b expected %b", cyc, m_instr,
          {valid_d, illegal_d, reg_write_d, mem_write_d, jump_d, branch_d, stall_f, flush_e}, e_ctl);
      end
      checks++;
      if ({rs1_d, rs2_d, rd_d, funct3_d, rd1_d, rd2_d} !== {rs1, rs2, m_instr[11:7], m_instr[14:12], e_rd1, e_rd2}) begin
        errors++; $display("FAIL rand_regs cyc%0d: rs1=%0d rs2=%0d rd1=%h rd2=%h expected %0d/%0d/%h/%h",
          cyc, rs1_d, rs2_d, rd1_d, rd2_d, rs1, rs2, e_rd1, e_rd2);
      end
      if (m_vld) begin
        checks++;
        if ({pc_d, pc_plus4_d} !== {m_pc, m_pc4}) begin
          errors++; $display("FAIL rand_pc cyc%0d: got %h/%h expected %h/%h", cyc, pc_d, pc_plus4_d, m_pc, m_pc4);
        end
      end
      if (m_vld && legal) begin
        e_imm = ref_imm(m_instr);
        e_res = (op == 7'h03) ? 2'b01 : (op == 7'h6F || op == 7'h67) ? 2'b10 : 2'b00;
        checks++;
        if ({imm_val_d, res_src_d, alu_src_a_d} !== {e_imm, e_res, op == 7'h17}) begin
          errors++; $display("FAIL rand_imm cyc%0d instr=%h: imm=%h res=%b a=%b expected %h/%b/%b",
            cyc, m_instr, imm_val_d, res_src_d, alu_src_a_d, e_imm, e_res, op == 7'h17);
        end
        if (op != 7'h6F && op != 7'h67) begin
          checks++;
          if ({alu_control_d, alu_src_b_d} !== {ref_alu(m_instr), !(op == 7'h33 || op == 7'h63)}) begin
            errors++; $display("FAIL rand_alu cyc%0d instr=%h: alu=%h b=%b expected %h/%b", cyc, m_instr,
              alu_control_d, alu_src_b_d, ref_alu(m_instr), !(op == 7'h33 || op == 7'h63));
          end
        end else begin
          checks++;
          if (adder_src_d !== (op == 7'h67)) begin
            errors++; $display("FAIL rand_adder cyc%0d: got %b expected %b", cyc, adder_src_d, op == 7'h67);
          end
        end
      end
      n_instr = m_instr; n_pc = m_pc; n_pc4 = m_pc4; n_vld = m_vld;
      if (flush_d) begin
        n_instr = 32'h00000013; n_vld = 0;
      end else if (!(stall_d || e_stall)) begin
        n_instr = instr_f; n_pc = pc_f; n_pc4 = pc_plus4_f; n_vld = 1;
      end
      do_write = reg_write_w && rd_w != 0;
      tick();
      if (do_write) m_rf[rd_w] = result_w;
      m_instr = n_instr; m_pc = n_pc; m_pc4 = n_pc4; m_vld = n_vld;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_regfile_bypass();
    test_addi();
    test_branch_jal();
    test_load_use();
    test_flush_stall();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
